// File: rtl/rvm_mem_arbiter.sv
// rvm_mem_arbiter: shares one memory port between fetch (F) and data (D)
// requesters. Round-robin grant, one transaction at a time, with a stall
// watchdog that aborts hung accesses with an error.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   f_req/f_addr/f_wdata/f_b_en/f_w_en   fetch request and its fields
//   f_ack/f_rdata/f_error          fetch completion pulse, read data, error
//   d_*                            same set for the data port
//   mem_addr/mem_wdata/mem_c_en/mem_b_en/mem_w_en   memory request bus
//   mem_rdata/mem_error            memory response, valid the cycle after accept
//   mem_stall                      memory not ready; accept = c_en & ~stall
//   busy                           arbiter not idle
module rvm_mem_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic [31:0] f_wdata,
  input  logic [3:0]  f_b_en,
  input  logic        f_w_en,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_b_en,
  input  logic        d_w_en,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic [3:0]  mem_b_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_stall,
  output logic        busy
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam bit          WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;   // 1: D was granted last
  logic          gnt_d, gnt_d_nxt;     // 1: current transaction belongs to D
  logic [AW-1:0] lat_addr, lat_addr_nxt;
  logic [DW-1:0] lat_wdata, lat_wdata_nxt;
  logic [BW-1:0] lat_b_en, lat_b_en_nxt;
  logic          lat_w_en, lat_w_en_nxt;
  logic [CW-1:0] stall_cnt, stall_cnt_nxt;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          f_elig, d_elig, pick_d;
  logic          in_access;

  // State, latched transaction and registered per-port responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      gnt_d     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_b_en  <= '0;
      lat_w_en  <= 1'b0;
      stall_cnt <= '0;
      f_ack     <= 1'b0;
      f_rdata   <= '0;
      f_error   <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_error   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      gnt_d     <= gnt_d_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_b_en  <= lat_b_en_nxt;
      lat_w_en  <= lat_w_en_nxt;
      stall_cnt <= stall_cnt_nxt;
      // Response lands only on the granted port; everything else clears
      f_ack     <= rsp_vld & ~gnt_d;
      f_rdata   <= (rsp_vld & ~gnt_d) ? rsp_rdata : '0;
      f_error   <= rsp_vld & ~gnt_d & rsp_err;
      d_ack     <= rsp_vld & gnt_d;
      d_rdata   <= (rsp_vld & gnt_d) ? rsp_rdata : '0;
      d_error   <= rsp_vld & gnt_d & rsp_err;
    end
  end

  // Next-state, arbitration and watchdog
  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    gnt_d_nxt     = gnt_d;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_b_en_nxt  = lat_b_en;
    lat_w_en_nxt  = lat_w_en;
    stall_cnt_nxt = stall_cnt;
    rsp_vld       = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    // A port being acked this cycle still shows its stale req; ignore it
    f_elig        = f_req & ~f_ack;
    d_elig        = d_req & ~d_ack;
    pick_d        = d_elig & (~f_elig | ~last_d);

    case (state)
      IDLE: begin
        if (f_elig | d_elig) begin
          gnt_d_nxt     = pick_d;
          last_d_nxt    = pick_d;
          lat_addr_nxt  = pick_d ? d_addr  : f_addr;
          lat_wdata_nxt = pick_d ? d_wdata : f_wdata;
          lat_b_en_nxt  = pick_d ? d_b_en  : f_b_en;
          lat_w_en_nxt  = pick_d ? d_w_en  : f_w_en;
          stall_cnt_nxt = '0;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_stall) begin
          stall_cnt_nxt = '0;
          state_nxt     = RESP;
        end else if (WD_EN && (stall_cnt == CW'(TIMEOUT - 1))) begin
          // Hung access: complete it with an error and zero data
          rsp_vld       = 1'b1;
          rsp_err       = 1'b1;
          stall_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else if (stall_cnt != '1) begin
          stall_cnt_nxt = stall_cnt + CW'(1);
        end
      end
      RESP: begin
        rsp_vld   = 1'b1;
        rsp_rdata = mem_rdata;
        rsp_err   = mem_error;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory bus is live only in ACCESS; decoded from state so reset drops it at once
  assign in_access = (state == ACCESS);
  assign mem_c_en  = in_access;
  assign mem_addr  = in_access ? lat_addr  : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;
  assign mem_b_en  = in_access ? lat_b_en  : '0;
  assign mem_w_en  = in_access & lat_w_en;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Testbench for rvm_mem_arbiter. Three instances share stimulus:
// g_dut[0] uses TIMEOUT=16, g_dut[1] TIMEOUT=4, g_dut[2] TIMEOUT=0.
module tb_rvm_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req, d_req, f_w_en, d_w_en, mem_error, mem_stall;
  logic [31:0] f_addr, f_wdata, d_addr, d_wdata, mem_rdata;
  logic [3:0]  f_b_en, d_b_en;

  logic        f_ack_v [3];
  logic [31:0] f_rdata_v [3];
  logic        f_error_v [3];
  logic        d_ack_v [3];
  logic [31:0] d_rdata_v [3];
  logic        d_error_v [3];
  logic [31:0] mem_addr_v [3];
  logic [31:0] mem_wdata_v [3];
  logic        mem_c_en_v [3];
  logic [3:0]  mem_b_en_v [3];
  logic        mem_w_en_v [3];
  logic        busy_v [3];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rvm_mem_arbiter #(
      .TIMEOUT(g == 0 ? 16 : (g == 1 ? 4 : 0)),
      .CW     (5)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_wdata  (f_wdata),
      .f_b_en   (f_b_en),
      .f_w_en   (f_w_en),
      .f_ack    (f_ack_v[g]),
      .f_rdata  (f_rdata_v[g]),
      .f_error  (f_error_v[g]),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_b_en   (d_b_en),
      .d_w_en   (d_w_en),
      .d_ack    (d_ack_v[g]),
      .d_rdata  (d_rdata_v[g]),
      .d_error  (d_error_v[g]),
      .mem_addr (mem_addr_v[g]),
      .mem_wdata(mem_wdata_v[g]),
      .mem_c_en (mem_c_en_v[g]),
      .mem_b_en (mem_b_en_v[g]),
      .mem_w_en (mem_w_en_v[g]),
      .mem_rdata(mem_rdata),
      .mem_error(mem_error),
      .mem_stall(mem_stall),
      .busy     (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic clear_inputs;
    f_req = 0; f_addr = '0; f_wdata = '0; f_b_en = '0; f_w_en = 0;
    d_req = 0; d_addr = '0; d_wdata = '0; d_b_en = '0; d_w_en = 0;
    mem_rdata = '0; mem_error = 0; mem_stall = 0;
  endtask

  // Reset released at a falling edge; the next rising edge is "edge 0"
  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if ({f_ack_v[g], f_rdata_v[g], f_error_v[g], d_ack_v[g], d_rdata_v[g], d_error_v[g],
           mem_addr_v[g], mem_wdata_v[g], mem_c_en_v[g], mem_b_en_v[g], mem_w_en_v[g], busy_v[g]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got c_en=%0b busy=%0b addr=%h f_ack=%0b d_ack=%0b, want all 0",
                 g, mem_c_en_v[g], busy_v[g], mem_addr_v[g], f_ack_v[g], d_ack_v[g]);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy_v[0] !== 1'b0 || mem_c_en_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%0b c_en=%0b, want 0 0", busy_v[0], mem_c_en_v[0]);
    end
  endtask

  task automatic test_fetch_read;
    do_reset();
    f_req = 1; f_addr = 32'h100; f_w_en = 0; f_b_en = 4'hF; mem_stall = 0;
    @(negedge clk);  // cycle 1
    n_vec++;
    if (mem_c_en_v[0] !== 1'b1 || mem_addr_v[0] !== 32'h100 || busy_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_c1_bus: got c_en=%0b addr=%h busy=%0b, want 1 00000100 1", mem_c_en_v[0], mem_addr_v[0], busy_v[0]);
    end
    @(negedge clk);  // cycle 2 (RESP)
    mem_rdata = 32'hDEADBEEF; mem_error = 0;
    n_vec++;
    if (mem_c_en_v[0] !== 1'b0 || f_ack_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c2: got c_en=%0b f_ack=%0b, want 0 0", mem_c_en_v[0], f_ack_v[0]);
    end
    @(negedge clk);  // cycle 3
    n_vec++;
    if (f_ack_v[0] !== 1'b1 || f_rdata_v[0] !== 32'hDEADBEEF || f_error_v[0] !== 1'b0 || d_ack_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c3_ack: got f_ack=%0b f_rdata=%h f_error=%0b d_ack=%0b, want 1 deadbeef 0 0",
               f_ack_v[0], f_rdata_v[0], f_error_v[0], d_ack_v[0]);
    end
    f_req = 0; mem_rdata = 32'h12345678;
    @(negedge clk);  // cycle 4
    n_vec++;
    if (f_ack_v[0] !== 1'b0 || f_rdata_v[0] !== 32'h0 || busy_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c4_clear: got f_ack=%0b f_rdata=%h busy=%0b, want 0 0 0", f_ack_v[0], f_rdata_v[0], busy_v[0]);
    end
  endtask

  task automatic test_tie;
    logic        exp_cen, exp_fa, exp_da;
    logic [31:0] exp_addr;
    do_reset();
    f_req = 1; f_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; mem_stall = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_cen  = (c % 3 == 1);
      exp_addr = !exp_cen ? 32'h0 : (c == 4 ? 32'h2000 : 32'h1000);
      exp_fa   = (c == 3);
      exp_da   = (c == 6);
      n_vec++;
      if (mem_c_en_v[0] !== exp_cen || mem_addr_v[0] !== exp_addr || f_ack_v[0] !== exp_fa || d_ack_v[0] !== exp_da) begin
        n_err++;
        $display("FAIL tie_c%0d: got c_en=%0b addr=%h f_ack=%0b d_ack=%0b, want %0b %h %0b %0b",
                 c, mem_c_en_v[0], mem_addr_v[0], f_ack_v[0], d_ack_v[0], exp_cen, exp_addr, exp_fa, exp_da);
      end
    end
    // Dropping req mid-transaction still lets the F access finish
    f_req = 0; d_req = 0;
    @(negedge clk);  // cycle 8 RESP
    @(negedge clk);  // cycle 9
    n_vec++;
    if (f_ack_v[0] !== 1'b1 || d_ack_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL tie_dropped_req_ack: got f_ack=%0b d_ack=%0b, want 1 0", f_ack_v[0], d_ack_v[0]);
    end
  endtask

  task automatic test_stall;
    do_reset();
    d_req = 1; d_addr = 32'h20; d_wdata = 32'h55; d_b_en = 4'hF; d_w_en = 1; mem_stall = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) mem_stall = 0;
      n_vec++;
      if (c <= 4) begin
        if (mem_c_en_v[0] !== 1'b1 || mem_w_en_v[0] !== 1'b1 || mem_addr_v[0] !== 32'h20 ||
            mem_wdata_v[0] !== 32'h55 || mem_b_en_v[0] !== 4'hF || d_ack_v[0] !== 1'b0) begin
          n_err++;
          $display("FAIL stall_bus_c%0d: got c_en=%0b w_en=%0b addr=%h wdata=%h b_en=%h d_ack=%0b, want 1 1 20 55 f 0",
                   c, mem_c_en_v[0], mem_w_en_v[0], mem_addr_v[0], mem_wdata_v[0], mem_b_en_v[0], d_ack_v[0]);
        end
      end else begin
        if (mem_c_en_v[0] !== 1'b0 || d_ack_v[0] !== (c == 6) || f_ack_v[0] !== 1'b0) begin
          n_err++;
          $display("FAIL stall_resp_c%0d: got c_en=%0b d_ack=%0b f_ack=%0b, want 0 %0b 0",
                   c, mem_c_en_v[0], d_ack_v[0], f_ack_v[0], (c == 6));
        end
      end
      if (c == 6) d_req = 0;
    end
  endtask

  task automatic test_watchdog;
    int hung;
    do_reset();
    d_req = 1; d_addr = 32'h40; d_w_en = 0; d_b_en = 4'hF; mem_stall = 1;
    mem_rdata = 32'hA5A5A5A5; mem_error = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (mem_c_en_v[1] !== (c <= 4) || d_ack_v[1] !== (c == 5)) begin
        n_err++;
        $display("FAIL wd4_c%0d: got c_en=%0b d_ack=%0b, want %0b %0b", c, mem_c_en_v[1], d_ack_v[1], (c <= 4), (c == 5));
      end
      if (c == 5) begin
        n_vec++;
        if (d_error_v[1] !== 1'b1 || d_rdata_v[1] !== 32'h0 || busy_v[1] !== 1'b0 || f_ack_v[1] !== 1'b0) begin
          n_err++;
          $display("FAIL wd4_abort: got d_error=%0b d_rdata=%h busy=%0b f_ack=%0b, want 1 0 0 0",
                   d_error_v[1], d_rdata_v[1], busy_v[1], f_ack_v[1]);
        end
        d_req = 0;
      end
      if (c == 6) begin
        n_vec++;
        if (busy_v[1] !== 1'b0 || d_error_v[1] !== 1'b0) begin
          n_err++;
          $display("FAIL wd4_after: got busy=%0b d_error=%0b, want 0 0", busy_v[1], d_error_v[1]);
        end
      end
    end
    hung = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_c_en_v[2] === 1'b1 && d_ack_v[2] === 1'b0) hung++;
      @(negedge clk);
    end
    n_vec++;
    if (hung !== 40) begin
      n_err++;
      $display("FAIL wd0_waits: got %0d stalled cycles in ACCESS, want 40", hung);
    end
  endtask

  task automatic test_mem_error;
    do_reset();
    f_req = 1; f_addr = 32'h300; f_b_en = 4'hF; mem_stall = 0;
    @(negedge clk);                    // cycle 1
    @(negedge clk);                    // cycle 2 RESP
    mem_rdata = 32'h0BADF00D; mem_error = 1;
    @(negedge clk);                    // cycle 3
    n_vec++;
    if (f_ack_v[0] !== 1'b1 || f_error_v[0] !== 1'b1 || f_rdata_v[0] !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL memerr_ack: got f_ack=%0b f_error=%0b f_rdata=%h, want 1 1 0badf00d", f_ack_v[0], f_error_v[0], f_rdata_v[0]);
    end
    f_req = 0; mem_error = 0;
    @(negedge clk);                    // cycle 4
    n_vec++;
    if (f_ack_v[0] !== 1'b0 || f_error_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL memerr_clear: got f_ack=%0b f_error=%0b, want 0 0", f_ack_v[0], f_error_v[0]);
    end
    f_req = 1; f_addr = 32'h304;
    @(negedge clk);                    // ACCESS
    @(negedge clk);                    // RESP
    mem_rdata = 32'h11112222; mem_error = 0;
    @(negedge clk);                    // ack
    n_vec++;
    if (f_ack_v[0] !== 1'b1 || f_error_v[0] !== 1'b0 || f_rdata_v[0] !== 32'h11112222) begin
      n_err++;
      $display("FAIL memerr_next_ok: got f_ack=%0b f_error=%0b f_rdata=%h, want 1 0 11112222", f_ack_v[0], f_error_v[0], f_rdata_v[0]);
    end
    f_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    do_reset();
    f_req = 1; f_addr = 32'h500; d_req = 1; d_addr = 32'h600; mem_stall = 1;
    @(negedge clk);  // cycle 1 ACCESS, F granted
    n_vec++;
    if (mem_c_en_v[0] !== 1'b1 || mem_addr_v[0] !== 32'h500) begin
      n_err++;
      $display("FAIL rstmid_pre: got c_en=%0b addr=%h, want 1 00000500", mem_c_en_v[0], mem_addr_v[0]);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (mem_c_en_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || mem_addr_v[0] !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async: got c_en=%0b busy=%0b addr=%h, want 0 0 0", mem_c_en_v[0], busy_v[0], mem_addr_v[0]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (f_ack_v[0] !== 1'b0 || d_ack_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_noack: got f_ack=%0b d_ack=%0b busy=%0b, want 0 0 0", f_ack_v[0], d_ack_v[0], busy_v[0]);
      end
    end
    reset = 1'b0; mem_stall = 0;
    @(negedge clk);  // cycle 1 after release
    n_vec++;
    if (mem_c_en_v[0] !== 1'b1 || mem_addr_v[0] !== 32'h500) begin
      n_err++;
      $display("FAIL rstmid_regrant_f: got c_en=%0b addr=%h, want 1 00000500", mem_c_en_v[0], mem_addr_v[0]);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (f_ack_v[0] !== 1'b1 || d_ack_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_f_ack: got f_ack=%0b d_ack=%0b, want 1 0", f_ack_v[0], d_ack_v[0]);
    end
    f_req = 0; d_req = 0;
    repeat (4) @(negedge clk);
  endtask

  // Random traffic against a transaction-level model: requesters hold until
  // acked, memory stalls randomly; grant order follows the round-robin rule.
  task automatic test_random(input int n_cyc);
    logic        rq [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rb [2];
    logic        rwe [2];
    logic        obs_ack [2];
    logic [31:0] obs_rd [2];
    logic        obs_er [2];
    logic        prev_elig [2];
    logic        prev_busy, resp_now, ack_due, exp_er, any;
    logic [31:0] exp_rd;
    int          cur, last, g, stall_run, grants, acks;

    do_reset();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; ra[p] = '0; rw[p] = '0; rb[p] = '0; rwe[p] = 0; prev_elig[p] = 0;
    end
    prev_busy = 0; resp_now = 0; ack_due = 0; exp_er = 0; exp_rd = '0;
    cur = 0; last = 1; stall_run = 0; grants = 0; acks = 0;

    for (int c = 0; c < n_cyc + 40; c++) begin
      @(negedge clk);
      obs_ack[0] = f_ack_v[0];   obs_ack[1] = d_ack_v[0];
      obs_rd[0]  = f_rdata_v[0]; obs_rd[1]  = d_rdata_v[0];
      obs_er[0]  = f_error_v[0]; obs_er[1]  = d_error_v[0];

      // Response check
      n_vec++;
      if (ack_due) begin
        acks++;
        if (obs_ack[cur] !== 1'b1 || obs_ack[1-cur] !== 1'b0 || obs_rd[cur] !== exp_rd || obs_er[cur] !== exp_er) begin
          n_err++;
          $display("FAIL rnd_ack c%0d port%0d: got ack=%0b/%0b rdata=%h err=%0b, want ack on port%0d rdata=%h err=%0b",
                   c, cur, obs_ack[0], obs_ack[1], obs_rd[cur], obs_er[cur], cur, exp_rd, exp_er);
        end
      end else if (obs_ack[0] !== 1'b0 || obs_ack[1] !== 1'b0 || obs_rd[0] !== '0 || obs_rd[1] !== '0) begin
        n_err++;
        $display("FAIL rnd_noack c%0d: got ack=%0b/%0b rdata=%h/%h, want 0", c, obs_ack[0], obs_ack[1], obs_rd[0], obs_rd[1]);
      end
      ack_due = 0;

      // Grant check: an idle arbiter with an eligible requester must grant it
      if (!prev_busy) begin
        any = prev_elig[0] | prev_elig[1];
        g   = (prev_elig[0] && prev_elig[1]) ? 1 - last : (prev_elig[1] ? 1 : 0);
        n_vec++;
        if (mem_c_en_v[0] !== any) begin
          n_err++;
          $display("FAIL rnd_grant_cen c%0d: got c_en=%0b, want %0b", c, mem_c_en_v[0], any);
        end
        if (any) begin
          cur = g; last = g; grants++;
        end
      end
      if (mem_c_en_v[0] === 1'b1) begin
        n_vec++;
        if (mem_addr_v[0] !== ra[cur] || mem_wdata_v[0] !== rw[cur] || mem_b_en_v[0] !== rb[cur] || mem_w_en_v[0] !== rwe[cur]) begin
          n_err++;
          $display("FAIL rnd_bus c%0d port%0d: got addr=%h wdata=%h b_en=%h w_en=%0b, want %h %h %h %0b",
                   c, cur, mem_addr_v[0], mem_wdata_v[0], mem_b_en_v[0], mem_w_en_v[0], ra[cur], rw[cur], rb[cur], rwe[cur]);
        end
      end

      // Memory response data; garbage outside the RESP cycle
      mem_rdata = $urandom;
      mem_error = 1'($urandom_range(0, 1));
      if (resp_now) begin
        exp_rd = mem_rdata; exp_er = mem_error; ack_due = 1; resp_now = 0;
      end

      // Requesters: drop on ack, otherwise maybe raise a new request
      for (int p = 0; p < 2; p++) begin
        if (obs_ack[p]) rq[p] = 0;
        else if (!rq[p] && c < n_cyc && $urandom_range(0, 2) == 0) begin
          rq[p] = 1; ra[p] = $urandom; rw[p] = $urandom;
          rb[p] = 4'($urandom_range(0, 15)); rwe[p] = 1'($urandom_range(0, 1));
        end
      end
      f_req = rq[0]; f_addr = ra[0]; f_wdata = rw[0]; f_b_en = rb[0]; f_w_en = rwe[0];
      d_req = rq[1]; d_addr = ra[1]; d_wdata = rw[1]; d_b_en = rb[1]; d_w_en = rwe[1];

      // Stall runs are kept below the 16-cycle watchdog
      mem_stall = (stall_run < 5) ? ($urandom_range(0, 2) == 0) : 1'b0;
      stall_run = mem_stall ? stall_run + 1 : 0;
      if (mem_c_en_v[0] === 1'b1 && !mem_stall) resp_now = 1;

      for (int p = 0; p < 2; p++) prev_elig[p] = rq[p] && !obs_ack[p];
      prev_busy = busy_v[0];
    end
    n_vec++;
    if (grants !== acks || grants < 50) begin
      n_err++;
      $display("FAIL rnd_complete: got grants=%0d acks=%0d, want equal and at least 50", grants, acks);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_fetch_read();
    test_tie();
    test_stall();
    test_watchdog();
    test_mem_error();
    test_reset_midop();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvm_mem_arbiter.md
Name: rvm_mem_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (F) and data load/store (D).
- Grants one transaction at a time, round-robin. Drives the memory bus, waits out mem_stall, and returns read data, error and a one-cycle ack to the granted port.
- Includes a stall watchdog that aborts hung accesses with an error.
- Sits between the core control and the memory interface pins.

Parameters:
- TIMEOUT, 16, consecutive mem_stall cycles in ACCESS before abort; 0 disables the watchdog.
- CW, 5, width of the stall counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held with fields stable until f_ack.
- f_addr  in  32  fetch address.
- f_wdata  in  32  fetch write data (normally unused).
- f_b_en  in  4  fetch byte enables.
- f_w_en  in  1  fetch write (1) / read (0).
- f_ack  out  1  one-cycle completion pulse.
- f_rdata  out  32  read data, valid while f_ack=1.
- f_error  out  1  error, valid while f_ack=1.
- d_req, d_addr, d_wdata, d_b_en, d_w_en, d_ack, d_rdata, d_error: the same set for the data port.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_c_en  out  1  memory chip enable.
- mem_b_en  out  4  memory byte enables.
- mem_w_en  out  1  memory write enable.
- mem_rdata  in  32  read data, valid the cycle after acceptance.
- mem_error  in  1  error, valid the cycle after acceptance.
- mem_stall  in  1  memory not ready; a request is accepted in a cycle where mem_c_en=1 and mem_stall=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - state=IDLE.
  - last_grant=D, so F wins the first tie.
  - Stall counter 0; latched transaction fields 0.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and mem_c_en drops asynchronously. No ack is issued, and the pending requester re-arbitrates after reset.
- IDLE:
  - Eligible requester: req=1 and its ack is not high this cycle. This prevents a stale req re-granting in the ack cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the port that is not last_grant.
  - On grant: latch addr/wdata/b_en/w_en and the grant id, update last_grant, go to ACCESS.
- ACCESS:
  - mem_c_en=1; mem_addr/wdata/b_en/w_en are driven from the latched registers.
  - mem_stall=0: accept the request, clear the counter, go to RESP.
  - mem_stall=1: increment the counter.
  - TIMEOUT!=0 and the counter reaches TIMEOUT-1 while stall is still high: go to IDLE. Next cycle the granted port sees ack=1, error=1, rdata=0.
- RESP:
  - mem_c_en=0.
  - At the clock edge, register mem_rdata and mem_error into the granted port's rdata/error, set its ack, and go to IDLE.
  - Writes also return ack; rdata is whatever the memory drives.
- Outputs outside ACCESS: mem_c_en=0 and mem_addr/wdata/b_en/w_en=0.
- ack, rdata and error are all registered:
  - ack is high for exactly one cycle.
  - rdata/error are cleared to 0 on the cycle after ack.
  - The non-granted port's ack/rdata/error stay 0.
- Latency with no stall: req sampled at edge 0 (IDLE), ACCESS in cycle 1, RESP in cycle 2, ack in cycle 3. Each stall cycle adds 1.
- The arbiter is non-preemptive: a req arriving mid-transaction waits.
- req dropped before ack: protocol violation. The transaction still completes and the ack is still pulsed.
- In the ack cycle the arbiter is already in IDLE, so the other port can be granted that same cycle. Back-to-back throughput is 1 transaction per 3 cycles.
- Counter behaviour: saturates and never wraps, is cleared on entry to ACCESS, and is unused when TIMEOUT=0 (a stall then waits indefinitely).

Test Plan:
- Fetch read: f_req=1, f_addr=0x100, f_w_en=0, mem_stall=0, mem_rdata=0xDEADBEEF. Required: mem_c_en=1 with mem_addr=0x100 in cycle 1; f_ack=1 with f_rdata=0xDEADBEEF and f_error=0 in cycle 3; d_ack stays 0.
- Tie: f_req and d_req raised together after reset, both held until acked. Required grant order F then D then F; mem_addr alternates f_addr/d_addr; each ack is a single pulse; no duplicate grant in an ack cycle.
- Stall: d write, addr 0x20, wdata 0x55, b_en 0xF, mem_stall=1 for 3 ACCESS cycles. Required: mem_c_en/mem_w_en/bus fields stable for 4 cycles; d_ack in cycle 6.
- Watchdog: TIMEOUT=4, mem_stall stuck at 1. Required: mem_c_en high for exactly 4 cycles, then d_ack=1 with d_error=1 and d_rdata=0; busy=0 afterwards. With TIMEOUT=0 under the same stimulus, the arbiter waits indefinitely.
- Memory error: mem_error=1 in the RESP cycle of a fetch. Required: f_ack=1 and f_error=1 in the next cycle; next transaction error=0.
- Reset mid-op: assert reset during ACCESS. Required: mem_c_en=0 asynchronously, no ack, busy=0. After release, the held f_req is granted first.
